// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate-generation stage between IF/ID and ID/EX.
// Decodes the format from the opcode and builds the sign-extended immediate.
// The result is registered behind valid/ready with a main entry plus one skid entry.
// Optional feature macro IMM_GEN_TARGET_EN adds out_target = pc + imm for the B and J formats.
module imm_gen_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc
`ifdef IMM_GEN_TARGET_EN
    ,
    output logic [XLEN-1:0] out_target
`endif
);

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
`ifdef IMM_GEN_TARGET_EN
        logic [XLEN-1:0] target;
`endif
    } entry_t;

    entry_t     dec;
    entry_t     main_q, main_d, skid_q, skid_d;
    logic       main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic       accept;
    logic [6:0] opcode;
    logic       s;

    assign opcode = in_inst[6:0];
    assign s      = in_inst[31];

    // Decode the incoming instruction into a full entry ahead of the registers.
    always_comb begin
        dec         = '0;
        dec.inst    = in_inst;
        dec.pc      = in_pc;
        dec.fmt     = FmtNone;
        dec.illegal = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: dec.fmt = FmtU;
            7'b1101111:             dec.fmt = FmtJ;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b1110011, 7'b0001111: dec.fmt = FmtI;
            7'b0100011:             dec.fmt = FmtS;
            7'b1100011:             dec.fmt = FmtB;
            7'b0110011:             dec.fmt = FmtNone;
            default:                dec.illegal = 1'b1;
        endcase
        case (dec.fmt)
            FmtI:    dec.imm = {{(XLEN-11){s}}, in_inst[30:20]};
            FmtS:    dec.imm = {{(XLEN-11){s}}, in_inst[30:25], in_inst[11:7]};
            FmtB:    dec.imm = {{(XLEN-12){s}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            FmtU:    dec.imm = {{(XLEN-31){s}}, in_inst[30:12], 12'b0};
            FmtJ:    dec.imm = {{(XLEN-20){s}}, in_inst[19:12], in_inst[20], in_inst[30:21],
                                1'b0};
            default: dec.imm = '0;
        endcase
`ifdef IMM_GEN_TARGET_EN
        // JALR is I-format, so it deliberately gets no target here.
        dec.target = (dec.fmt == FmtB || dec.fmt == FmtJ) ? in_pc + dec.imm : '0;
`endif
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;

    // Next-state for main/skid: flush wins, then hold, then drain skid, then load main.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_valid_q && !out_ready) begin
            if (accept) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            // Skid is only ever full while main is full, and accept is blocked then.
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            main_d       = dec;
            main_valid_d = 1'b1;
        end else begin
            main_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset clearing data as well as valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;
`ifdef IMM_GEN_TARGET_EN
    assign out_target  = main_q.target;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance share stimulus.
// Target checks are compiled in only with IMM_GEN_TARGET_EN.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [31:0] pc;
    logic [63:0] pc64;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_inst32, out_pc32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64, out_pc64;
    logic [31:0] out_inst64;
    logic [2:0]  out_fmt64;
`ifdef IMM_GEN_TARGET_EN
    logic [31:0] out_target32;
    logic [63:0] out_target64;
`endif

    int total = 0;
    int bad   = 0;

    assign pc64 = {32'h0, pc};

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_pc(pc), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32),
        .out_inst(out_inst32), .out_pc(out_pc32)
`ifdef IMM_GEN_TARGET_EN
        , .out_target(out_target32)
`endif
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
        .out_inst(out_inst64), .out_pc(out_pc64)
`ifdef IMM_GEN_TARGET_EN
        , .out_target(out_target64)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] p);
        in_valid = 1'b1;
        in_inst  = inst;
        pc       = p;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = 32'h0; pc = 32'h0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_valid",   64'(out_valid32),   64'd0);
        check_eq("rst_ready",   64'(in_ready32),    64'd1);
        check_eq("rst_imm",     64'(out_imm32),     64'd0);
        check_eq("rst_fmt",     64'(out_fmt32),     64'd0);
        check_eq("rst_illegal", 64'(out_illegal32), 64'd0);
        check_eq("rst_inst",    64'(out_inst32),    64'd0);
        check_eq("rst_pc",      64'(out_pc64),      64'd0);

        // beq x0,x0,-4 at 0x100
        offer(32'hFE000EE3, 32'h100);
        step();
        in_valid = 1'b0;
        check_eq("beq_valid", 64'(out_valid32), 64'd1);
        check_eq("beq_fmt",   64'(out_fmt32),   64'd3);
        check_eq("beq_imm",   64'(out_imm32),   64'hFFFF_FFFC);
        check_eq("beq_pc",    64'(out_pc32),    64'h100);
`ifdef IMM_GEN_TARGET_EN
        check_eq("beq_target", 64'(out_target32), 64'hFC);
`endif
        step();
        check_eq("idle_valid", 64'(out_valid32), 64'd0);

        // Back-to-back JAL, LUI, SW
        offer(32'h0080006F, 32'h200);
        step();
        check_eq("jal_valid", 64'(out_valid32), 64'd1);
        check_eq("jal_fmt",   64'(out_fmt32),   64'd5);
        check_eq("jal_imm",   64'(out_imm32),   64'h8);
`ifdef IMM_GEN_TARGET_EN
        check_eq("jal_target", 64'(out_target32), 64'h208);
`endif
        offer(32'h123450B7, 32'h204);
        step();
        check_eq("lui_valid", 64'(out_valid32), 64'd1);
        check_eq("lui_fmt",   64'(out_fmt32),   64'd4);
        check_eq("lui_imm",   64'(out_imm32),   64'h1234_5000);
`ifdef IMM_GEN_TARGET_EN
        check_eq("lui_target", 64'(out_target32), 64'h0);
`endif
        offer(32'hFE20AC23, 32'h208);
        step();
        in_valid = 1'b0;
        check_eq("sw_valid", 64'(out_valid32), 64'd1);
        check_eq("sw_fmt",   64'(out_fmt32),   64'd2);
        check_eq("sw_imm",   64'(out_imm32),   64'hFFFF_FFF8);
        check_eq("sw_imm64", out_imm64,        64'hFFFF_FFFF_FFFF_FFF8);

        // LUI with bit 31 set: sign extension at XLEN=64
        offer(32'h800000B7, 32'h300);
        step();
        check_eq("lui64_fmt", 64'(out_fmt64), 64'd4);
        check_eq("lui64_imm", out_imm64,      64'hFFFF_FFFF_8000_0000);
        check_eq("lui32_imm", 64'(out_imm32), 64'h8000_0000);
        // Unknown opcode
        offer(32'h0000007F, 32'h304);
        step();
        check_eq("ill_fmt",     64'(out_fmt64),     64'd0);
        check_eq("ill_illegal", 64'(out_illegal64), 64'd1);
        check_eq("ill_imm",     out_imm64,          64'd0);
        // OP opcode: no immediate but legal
        offer(32'h00000033, 32'h308);
        step();
        in_valid = 1'b0;
        check_eq("op_fmt",     64'(out_fmt64),     64'd0);
        check_eq("op_illegal", 64'(out_illegal64), 64'd0);
        step();

        // Stall: A in main, B in skid, C held upstream
        out_ready = 1'b0;
        offer(32'h00500093, 32'h400);
        step();
        check_eq("stall_a_ready", 64'(in_ready32), 64'd1);
        offer(32'hFFF00093, 32'h404);
        step();
        check_eq("stall_b_ready", 64'(in_ready32), 64'd0);
        check_eq("stall_b_inst",  64'(out_inst32), 64'h00500093);
        offer(32'h07B00093, 32'h408);
        step();
        check_eq("stall_c_ready", 64'(in_ready32), 64'd0);
        check_eq("stall_hold_a",  64'(out_inst32), 64'h00500093);
        check_eq("stall_a_imm",   64'(out_imm32),  64'h5);
        out_ready = 1'b1;
        step();
        check_eq("drain_b_valid", 64'(out_valid32), 64'd1);
        check_eq("drain_b_inst",  64'(out_inst32),  64'hFFF00093);
        check_eq("drain_b_imm",   64'(out_imm32),   64'hFFFF_FFFF);
        check_eq("drain_ready",   64'(in_ready32),  64'd1);
        step();
        in_valid = 1'b0;
        check_eq("drain_c_valid", 64'(out_valid32), 64'd1);
        check_eq("drain_c_inst",  64'(out_inst32),  64'h07B00093);
        check_eq("drain_c_imm",   64'(out_imm32),   64'h7B);
        step();
        check_eq("drain_empty", 64'(out_valid32), 64'd0);

        // Flush with both entries full and a new offer
        out_ready = 1'b0;
        offer(32'h00100093, 32'h500);
        step();
        offer(32'h00200093, 32'h504);
        step();
        check_eq("flush_pre_ready", 64'(in_ready32), 64'd0);
        offer(32'h00300093, 32'h508);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", 64'(out_valid32), 64'd0);
        check_eq("flush_ready", 64'(in_ready32),  64'd1);
        out_ready = 1'b1;
        step();
        check_eq("flush_stays_empty", 64'(out_valid32), 64'd0);

        // Reset while stalled with two entries
        out_ready = 1'b0;
        offer(32'hFE000EE3, 32'h600);
        step();
        offer(32'h0080006F, 32'h604);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst2_valid", 64'(out_valid32), 64'd0);
        check_eq("rst2_ready", 64'(in_ready32),  64'd1);
        check_eq("rst2_imm",   out_imm64,        64'd0);
        check_eq("rst2_fmt",   64'(out_fmt32),   64'd0);
        check_eq("rst2_inst",  64'(out_inst32),  64'd0);
        check_eq("rst2_pc",    64'(out_pc32),    64'd0);
`ifdef IMM_GEN_TARGET_EN
        check_eq("rst2_target", 64'(out_target32), 64'd0);
`endif
        out_ready = 1'b1;
        step();
        check_eq("rst2_no_ghost", 64'(out_valid32), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, parametrised immediate-generation stage for the RISC-V decode path. Decodes the instruction format from the opcode and produces the sign-extended immediate for all base formats (I, S, B, U, J) at XLEN 32 or 64. Results are registered behind a valid/ready interface with a 2-entry skid buffer. It sits between the IF/ID register and the ID/EX register, with flush support for branch redirects.

## Interface

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64; immediates sign-extended to XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop all held and incoming entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered state only).
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 unused.
- out_illegal  out  1  opcode not in the decode list below.
- out_inst  out  32  passthrough instruction.
- out_pc  out  XLEN  passthrough PC.
- out_target  out  XLEN  present only with IMM_GEN_TARGET_EN.

## Operation

Opcode decode uses in_inst[6:0]:
- 0110111 LUI and 0010111 AUIPC → U.
- 1101111 JAL → J.
- 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 1110011 SYSTEM, 0001111 FENCE → I.
- 0100011 STORE → S.
- 1100011 BRANCH → B.
- 0110011 OP → NONE with illegal=0.
- Any other opcode → NONE, imm=0, illegal=1.

Immediate construction, with s = inst[31] replicated to fill XLEN:
- I: {s, inst[30:20]}.
- S: {s, inst[30:25], inst[11:7]}.
- B: {s, inst[7], inst[30:25], inst[11:8], 0}.
- U: {s, inst[30:12], 12'b0}, sign-extended (matters at XLEN=64).
- J: {s, inst[19:12], inst[20], inst[30:21], 0}.

Storage and flow:
- Two entries: main (drives the outputs) and skid.
- Accept occurs when in_valid && in_ready. Fire occurs when out_valid && out_ready.
- Accept, main empty or firing → decoded entry loads main.
- Accept, main held (out_valid && !out_ready) → entry loads skid; in_ready drops next cycle.
- Fire with skid valid → skid moves to main, skid clears, in_ready rises next cycle.
- Fire with skid empty and no accept → out_valid clears.
- Entries are never lost, duplicated or reordered.

Flush:
- Highest priority. Next cycle both entries are invalid.
- An input offered in the flush cycle is discarded.
- in_ready=1 the cycle after a flush.

## Timing

- Latency: accepted in cycle N → on outputs in cycle N+1 (main path). The skid path adds stall cycles only.
- Throughput: 1 entry/cycle while out_ready=1.
- Outputs change only at the clock edge. Decode logic is combinational on the input side, before the registers.
- in_ready is registered-state only; it has no combinational path from out_ready.
- out_* data is stable while out_valid && !out_ready.
- Reset values: out_valid=0, in_ready=1. out_imm, out_fmt, out_illegal, out_inst, out_pc, out_target all 0. Skid is invalid.
- Reset mid-stall: everything is cleared the next cycle. Reset has priority over flush.
- Simultaneous flush and fire: the fired entry is consumed downstream; the stage is still empty next cycle.

## Configuration

- IMM_GEN_TARGET_EN defined:
  - out_target = pc + imm (mod 2^XLEN) for B and J formats.
  - For JALR and all other formats, out_target = 0.
  - out_target is registered and aligned with out_imm.
- Undefined: the out_target port and its adder are absent; all other behaviour is identical.

## Test plan

- XLEN=32, inst 0xFE000EE3 (beq x0,x0,-4), pc 0x100, out_ready=1 → next cycle: out_valid=1, fmt=3, imm=0xFFFFFFFC, target=0xFC (with macro).
- Back-to-back 0x0080006F (JAL +8), 0x123450B7 (LUI), 0xFE20AC23 (sw x2,-8(x1)) → imm 0x8 / 0x12345000 / 0xFFFFFFF8, fmt 5/4/2, on three consecutive cycles.
- XLEN=64, 0x800000B7 → imm 0xFFFFFFFF80000000, fmt=4. Inst 0x0000007F → fmt=0, illegal=1, imm=0.
- Hold out_ready=0 and offer 3 entries → first in main, second in skid, in_ready=0; third held upstream. Raise out_ready → all three emerge in order with no gaps, and in_ready returns to 1.
- Main and skid both full, assert flush with in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed and offered entries never appear.
- Assert rst while stalled with 2 entries → next cycle all outputs are at their reset values and in_ready=1.
